// File: rtl/memory_word_loader_pkg.sv
// Shared constants and state encoding for the word memory fill stage.
// Used by the loader, the memory and its readers.
package memory_word_loader_pkg;

   localparam int WORD_W         = 30;
   localparam int ADDR_W         = 7;
   localparam int BYTES_PER_WORD = 4;
   localparam int WORDS_MAX      = 100;
   localparam int IDX_W          = $clog2(BYTES_PER_WORD);
   localparam int LO_W           = 8 * (BYTES_PER_WORD - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      WRITE   = 2'd2,
      FINISH  = 2'd3
   } state_t;

   function automatic logic [ADDR_W-1:0] clamp_words(
      input logic [ADDR_W-1:0] n
   );
      return (n > ADDR_W'(WORDS_MAX)) ? ADDR_W'(WORDS_MAX) : n;
   endfunction

endpackage

// File: rtl/memory_word_loader_if.sv
// Byte stream handshake plus memory write port of the loader.
// master: byte source / memory side; slave: the loader.
interface memory_word_loader_if;
   import memory_word_loader_pkg::*;

   logic [7:0]        byte_in;
   logic              byte_valid;
   logic              byte_ready;
   logic              WR;
   logic [ADDR_W-1:0] wr_address_word;
   logic [WORD_W-1:0] wr_data_word;

   modport master (
      output byte_in, byte_valid,
      input  byte_ready, WR, wr_address_word, wr_data_word
   );

   modport slave (
      input  byte_in, byte_valid,
      output byte_ready, WR, wr_address_word, wr_data_word
   );

endinterface

// File: rtl/memory_word_loader.sv
// Packs a little-endian byte stream into 30-bit words and writes them
// to the word memory from address 0; ports: clk/rst, start/abort/word_count, bus, busy/done/fmt_error.
module memory_word_loader
   import memory_word_loader_pkg::*;
(
   input  logic              CLOCK_50,
   input  logic              RESET_N,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-1:0] word_count,
   memory_word_loader_if.slave bus,
   output logic              busy,
   output logic              done,
   output logic              fmt_error
);

   state_t            state, next_state;
   logic [IDX_W-1:0]  idx;
   logic [LO_W-1:0]   lo_bytes;
   logic [ADDR_W-1:0] n_words;
   logic [ADDR_W-1:0] addr;
   logic [WORD_W-1:0] data;
   logic              ready;
   logic              wr;
   logic              accept;
   logic              go;
   logic              last_byte;

   assign accept    = ready & bus.byte_valid;
   assign go        = (state == IDLE) & start & ~abort;
   assign last_byte = (idx == IDX_W'(BYTES_PER_WORD - 1));

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) state <= IDLE;
      else          state <= next_state;
   end

   always_comb begin
      next_state = state;
      unique case (state)
         IDLE: begin
            if (go)
               next_state = (word_count == '0) ? FINISH : COLLECT;
         end
         COLLECT: begin
            if (abort)
               next_state = IDLE;
            else if (accept && last_byte)
               next_state = WRITE;
         end
         WRITE: begin
            if (abort)
               next_state = IDLE;
            else if (addr == n_words - ADDR_W'(1))
               next_state = FINISH;
            else
               next_state = COLLECT;
         end
         FINISH: next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // abort suppresses the strobe/pulse of the cycle it arrives in
   always_comb begin
      ready = (state == COLLECT);
      wr    = (state == WRITE) & ~abort;
      busy  = (state == COLLECT) | (state == WRITE);
      done  = (state == FINISH) & ~abort;
   end

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         idx       <= '0;
         lo_bytes  <= '0;
         n_words   <= '0;
         addr      <= '0;
         data      <= '0;
         fmt_error <= 1'b0;
      end else begin
         if (go) begin
            n_words   <= clamp_words(word_count);
            addr      <= '0;
            fmt_error <= 1'b0;
         end
         if (abort || go) begin
            idx <= '0;
         end else if (accept) begin
            idx <= idx + IDX_W'(1);
            unique case (idx)
               2'd0: lo_bytes[7:0]   <= bus.byte_in;
               2'd1: lo_bytes[15:8]  <= bus.byte_in;
               2'd2: lo_bytes[23:16] <= bus.byte_in;
               default: begin
                  // top byte carries only bits [29:24]
                  data <= {bus.byte_in[5:0], lo_bytes};
                  if (bus.byte_in[7:6] != 2'b00)
                     fmt_error <= 1'b1;
               end
            endcase
         end
         if (wr)
            addr <= addr + ADDR_W'(1);
      end
   end

   assign bus.byte_ready      = ready;
   assign bus.WR              = wr;
   assign bus.wr_address_word = addr;
   assign bus.wr_data_word    = data;

endmodule
